// File: rtl/lbp_window_ctrl_if.sv
// Handshake bundle between the LBP window sequencer and its pixel source / window consumer.
// The master side is the sequencer; the slave side is the surrounding datapath or bench.
interface lbp_window_ctrl_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 9
);
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic             ce;
    logic             win_valid;
    logic             out_ready;
    logic [COL_W-1:0] win_col;
    logic [ROW_W-1:0] win_row;
    logic             win_border;
    logic             frame_done;
    logic             sof_err;

    modport master (
        input  in_valid, in_sof, out_ready,
        output in_ready, ce, win_valid, win_col, win_row, win_border, frame_done, sof_err
    );

    modport slave (
        output in_valid, in_sof, out_ready,
        input  in_ready, ce, win_valid, win_col, win_row, win_border, frame_done, sof_err
    );
endinterface

// File: rtl/lbp_window_ctrl.sv
// Sequencer for 3x3 LBP window line buffers: drives the shared shift enable, tracks the
// window centre, and drains the last line with IMG_W+1 flush shifts; a stalled window freezes ce.
module lbp_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    lbp_window_ctrl_if.master  bus
);
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int L_LAG = IMG_W + 1;
    localparam int N_TOT = N_PIX + L_LAG;
    localparam int CNT_W = $clog2(N_TOT + 1);

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] LAST_CE   = CNT_W'(N_TOT - 1);
    localparam logic [CNT_W-1:0] LAG_CNT   = CNT_W'(L_LAG);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] n_cnt;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic             win_valid_q;
    logic [COL_W-1:0] win_col_q;
    logic [ROW_W-1:0] win_row_q;
    logic             win_border_q;

    logic stall;
    logic in_ready_c;
    logic ce_c;
    logic sof_err_c;
    logic frame_done_c;
    logic nxt_border;

    assign stall      = win_valid_q & ~bus.out_ready;
    assign nxt_border = (nxt_row == '0) || (nxt_row == LAST_ROW) ||
                        (nxt_col == '0) || (nxt_col == LAST_COL);

    always_comb begin
        in_ready_c   = 1'b0;
        ce_c         = 1'b0;
        sof_err_c    = 1'b0;
        frame_done_c = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    // Pixels before the first sof are swallowed so upstream never blocks.
                    in_ready_c = 1'b1;
                    ce_c       = bus.in_valid & bus.in_sof;
                end
                S_RUN: begin
                    in_ready_c = ~stall;
                    ce_c       = bus.in_valid & ~stall;
                    sof_err_c  = bus.in_valid & ~stall & bus.in_sof;
                end
                S_FLUSH: begin
                    ce_c = ~stall;
                end
                default: begin
                    frame_done_c = win_valid_q & bus.out_ready;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            n_cnt        <= '0;
            nxt_col      <= '0;
            nxt_row      <= '0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            win_border_q <= 1'b0;
        end else begin
            if (ce_c) begin
                n_cnt <= n_cnt + 1'b1;
            end else if (frame_done_c) begin
                n_cnt <= '0;
            end

            case (state)
                S_IDLE:  if (ce_c) state <= S_RUN;
                S_RUN:   if (ce_c && n_cnt == LAST_PIX) state <= S_FLUSH;
                S_FLUSH: if (ce_c && n_cnt == LAST_CE) state <= S_DRAIN;
                default: if (frame_done_c) state <= S_IDLE;
            endcase

            // ce is blocked while a window is stalled, so a new window never overwrites one.
            if (ce_c && n_cnt >= LAG_CNT) begin
                win_valid_q  <= 1'b1;
                win_col_q    <= nxt_col;
                win_row_q    <= nxt_row;
                win_border_q <= nxt_border;
                if (nxt_col == LAST_COL) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == LAST_ROW) ? '0 : nxt_row + 1'b1;
                end else begin
                    nxt_col <= nxt_col + 1'b1;
                end
            end else if (win_valid_q && bus.out_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.ce         = ce_c;
    assign bus.sof_err    = sof_err_c;
    assign bus.frame_done = frame_done_c;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_border = win_border_q;
endmodule

// File: tb/tb_lbp_window_ctrl.sv
// Directed bench for lbp_window_ctrl on a 4x3 frame (12 pixels, centre lag 5, 17 shifts).
module tb_lbp_window_ctrl;
    logic clk = 1'b0;
    logic rst;

    lbp_window_ctrl_if #(.COL_W(2), .ROW_W(2)) bus ();

    lbp_window_ctrl #(.IMG_W(4), .IMG_H(3), .COL_W(2), .ROW_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Monitor state, written only by the monitor process.
    int         ce_total   = 0;
    int         fd_cnt     = 0;
    int         se_cnt     = 0;
    int         stall_seen = 0;
    int         stall_bad  = 0;
    logic       prev_wv    = 1'b0;
    logic [4:0] win_q[$];
    int         rise_q[$];

    logic stall_en = 1'b0;
    int   held     = 0;

    int base_ce, base_fd, base_se, base_win, base_rise, base_stall, base_bad;

    // Border flag per raster index: only (1,1) and (1,2) are interior.
    logic [11:0] exp_border = 12'b1111_1001_1111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wv = 1'b0;
            end else begin
                if (bus.win_valid && !prev_wv) rise_q.push_back(ce_total);
                prev_wv = bus.win_valid;
                if (bus.ce) ce_total++;
                if (bus.win_valid && bus.out_ready)
                    win_q.push_back({bus.win_border, bus.win_row, bus.win_col});
                if (bus.frame_done) fd_cnt++;
                if (bus.sof_err) se_cnt++;
                if (bus.win_valid && !bus.out_ready) begin
                    stall_seen++;
                    if (bus.ce || bus.in_ready || bus.win_row != 2'd0 || bus.win_col != 2'd2)
                        stall_bad++;
                end
            end
        end
    end

    // Consumer: ready except for three cycles while window (0,2) is presented, when enabled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_en) held = 0;
            if (stall_en && bus.win_valid && bus.win_row == 2'd0 && bus.win_col == 2'd2 && held < 3) begin
                bus.out_ready = 1'b0;
                held++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic snapshot();
        #1;
        base_ce    = ce_total;
        base_fd    = fd_cnt;
        base_se    = se_cnt;
        base_win   = win_q.size();
        base_rise  = rise_q.size();
        base_stall = stall_seen;
        base_bad   = stall_bad;
    endtask

    task automatic send_pixels(input int sof_pix);
        for (int i = 0; i < 12; i++) begin
            int  waited;
            logic taken;
            bus.in_valid = 1'b1;
            bus.in_sof   = (i == 0) || (i == sof_pix);
            waited = 0;
            taken  = 1'b0;
            while (!taken && waited < 20) begin
                @(negedge clk);
                taken = bus.ce;
                waited++;
                @(posedge clk);
                #1;
            end
            if (!taken) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (fd_cnt > base_fd) break;
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input int exp_sof);
        chk("ce_pulses", 32'(ce_total - base_ce), 32'd17);
        chk("frame_done_cnt", 32'(fd_cnt - base_fd), 32'd1);
        chk("sof_err_cnt", 32'(se_cnt - base_se), 32'(exp_sof));
        chk("window_cnt", 32'(win_q.size() - base_win), 32'd12);
        if (rise_q.size() > base_rise)
            chk("first_win_latency", 32'(rise_q[base_rise] - base_ce), 32'd6);
        else
            chk("first_win_seen", 32'd0, 32'd1);
        for (int k = 0; k < 12; k++) begin
            logic [1:0] r, c;
            logic [4:0] exp_w;
            r     = 2'(k / 4);
            c     = 2'(k % 4);
            exp_w = {exp_border[11-k], r, c};
            if (base_win + k < win_q.size())
                chk($sformatf("win%0d", k), 32'(win_q[base_win + k]), 32'(exp_w));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;

        // Reset holds in_ready and ce low.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ce_rdy", 32'({bus.ce, bus.in_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst", 32'({bus.win_valid, bus.ce, bus.in_ready, bus.frame_done, bus.sof_err}), 32'b00100);
        @(posedge clk);
        #1;

        // Plain frame, full throughput, border pattern.
        snapshot();
        send_pixels(-1);
        wait_done();
        check_frame(0);

        // Three-cycle downstream stall while (0,2) is presented.
        stall_en = 1'b1;
        snapshot();
        send_pixels(-1);
        wait_done();
        stall_en = 1'b0;
        check_frame(0);
        chk("stall_cycles", 32'(stall_seen - base_stall), 32'd3);
        chk("stall_frozen", 32'(stall_bad - base_bad), 32'd0);

        // Non-sof pixels in IDLE are swallowed without shifting.
        snapshot();
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_discard%0d", i), 32'({bus.ce, bus.in_ready}), 32'b01);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        send_pixels(-1);
        wait_done();
        check_frame(0);

        // Stray sof on pixel 6.
        snapshot();
        send_pixels(6);
        wait_done();
        check_frame(1);

        // Reset in the middle of the flush (after shift index 13, n = 14).
        send_pixels(-1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("flush_rst_ce_rdy", 32'({bus.ce, bus.in_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_rst_idle", 32'({bus.win_valid, bus.ce, bus.in_ready}), 32'b001);
        @(posedge clk);
        #1;
        snapshot();
        send_pixels(-1);
        wait_done();
        check_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
